// File: rtl/muon_event_readout_pkg.sv
// Shared constants and types for the muon event readout block.
package muon_readout_pkg;

  localparam int         TS_W        = 64;
  localparam int         FRAME_BYTES = 10;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;

  // Frame byte index of the first timestamp byte sent after SYNC (MSB first).
  localparam logic [2:0] FIRST_DATA_IDX = 3'(FRAME_BYTES - 3);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    CSUM
  } state_e;

endpackage

// File: rtl/muon_event_readout_if.sv
// Valid/ready byte link toward the host UART/USB bridge.
interface muon_event_readout_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/muon_event_readout_ts_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flags decoded from registered pointers.
module ts_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store incoming entries; writes into a full FIFO are ignored.
  // NOTE: the storage array is deliberately not reset -- the pointers alone
  // decide which entries are valid, and resetting a RAM costs a mux per bit.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  // Advance read/write pointers; the extra MSB tells full from empty.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/muon_event_readout.sv
// Buffers detector timestamps and drains them as 10-byte framed packets
// (SYNC, 8 timestamp bytes MSB first, XOR checksum) over a byte link.
module muon_event_readout
  import muon_readout_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TS_W-1:0]       ts_in_i,
  input  logic                  ts_valid_i,
  muon_event_readout_if.master  tx_if,
  output logic                  fifo_empty_o,
  output logic                  fifo_full_o,
  output logic [DROP_W-1:0]     drop_count_o
);

  state_e            state_q;
  logic [TS_W-1:0]   shift_q;
  logic [7:0]        csum_q;
  logic [2:0]        idx_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [DROP_W-1:0] drop_q;

  logic [TS_W-1:0]   head;
  logic              push;
  logic              pop;
  logic              accept;

  // Full is judged on pre-edge state, so a write colliding with a pop while
  // full is still dropped.
  assign push   = ts_valid_i && !fifo_full_o;
  assign accept = tx_valid_q && tx_if.tx_ready;
  assign pop    = !fifo_empty_o &&
                  ((state_q == IDLE) || ((state_q == CSUM) && accept));

  ts_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (ts_in_i),
    .dout_o  (head),
    .empty_o (fifo_empty_o),
    .full_o  (fifo_full_o)
  );

  // Framing FSM: every link output is a register updated only on start or accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty_o) begin
            shift_q    <= head;
            csum_q     <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            state_q    <= SYNC;
          end
        end
        SYNC: begin
          if (accept) begin
            tx_data_q <= shift_q[TS_W-1 -: 8];
            shift_q   <= {shift_q[TS_W-9:0], 8'h00};
            idx_q     <= FIRST_DATA_IDX;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            csum_q <= csum_q ^ tx_data_q;
            if (idx_q != 3'd0) begin
              tx_data_q <= shift_q[TS_W-1 -: 8];
              shift_q   <= {shift_q[TS_W-9:0], 8'h00};
              idx_q     <= idx_q - 3'd1;
            end else begin
              tx_data_q <= csum_q ^ tx_data_q;
              state_q   <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (!fifo_empty_o) begin
              // Back-to-back frame: go straight to SYNC with no idle cycle.
              shift_q   <= head;
              csum_q    <= '0;
              tx_data_q <= SYNC_BYTE;
              state_q   <= SYNC;
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating count of events lost to a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (ts_valid_i && fifo_full_o && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  end

  assign tx_if.tx_data  = tx_data_q;
  assign tx_if.tx_valid = tx_valid_q;
  assign drop_count_o   = drop_q;

endmodule

// File: tb/tb_muon_event_readout.sv
// Directed bench for muon_event_readout with a byte-level scoreboard:
// each stored event pushes its 10 expected frame bytes, and every byte
// accepted on the link is popped and compared.
module tb_muon_event_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ts_in;
  logic        ts_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic [15:0] drop_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q [$];

  muon_event_readout_if link ();

  muon_event_readout #(
    .DEPTH  (16),
    .DROP_W (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ts_in_i      (ts_in),
    .ts_valid_i   (ts_valid),
    .tx_if        (link),
    .fifo_empty_o (fifo_empty),
    .fifo_full_o  (fifo_full),
    .drop_count_o (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame: A5, timestamp bytes MSB first, XOR of those bytes.
  task automatic push_frame(input logic [63:0] ts);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(ts[i*8 +: 8]);
      x = x ^ ts[i*8 +: 8];
    end
    exp_q.push_back(x);
  endtask

  // One cycle: drive inputs at the falling edge; a byte presented with
  // ready high transfers at the next rising edge, so score it now.
  task automatic step(input logic rdy, input logic v, input logic [63:0] ts);
    @(negedge clk);
    link.tx_ready = rdy;
    ts_valid      = v;
    ts_in         = ts;
    if (link.tx_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_byte", 64'(exp_q.size()), 64'd1);
      end else begin
        check("tx_byte", 64'(link.tx_data), 64'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step(1'b1, 1'b0, 64'd0);
      cycles++;
    end
    check("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int guard;

    reset         = 1'b1;
    link.tx_ready = 1'b0;
    ts_valid      = 1'b0;
    ts_in         = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 64'(link.tx_valid), 64'd0);
    check("rst_tx_data",  64'(link.tx_data),  64'h00);
    check("rst_empty",    64'(fifo_empty),    64'd1);
    check("rst_full",     64'(fifo_full),     64'd0);
    check("rst_drop",     64'(drop_count),    64'd0);
    reset = 1'b0;

    // Single event with latency checks.
    step(1'b1, 1'b1, 64'h0123456789ABCDEF);
    push_frame(64'h0123456789ABCDEF);
    step(1'b1, 1'b0, 64'd0);
    check("lat_empty_low",  64'(fifo_empty),    64'd0);
    check("lat_valid_low",  64'(link.tx_valid), 64'd0);
    step(1'b1, 1'b0, 64'd0);
    check("lat_sof_valid",  64'(link.tx_valid), 64'd1);
    drain(50, c);
    check("single_cycles",  64'(c),             64'd9);
    step(1'b1, 1'b0, 64'd0);
    check("single_idle",    64'(link.tx_valid), 64'd0);
    check("single_empty",   64'(fifo_empty),    64'd1);

    // Backpressure right after 0x23 is presented.
    step(1'b1, 1'b1, 64'h0123456789ABCDEF);
    push_frame(64'h0123456789ABCDEF);
    guard = 0;
    while (exp_q.size() > 8 && guard < 20) begin
      step(1'b1, 1'b0, 64'd0);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 64'd0);
      check("bp_hold_valid", 64'(link.tx_valid), 64'd1);
      check("bp_hold_data",  64'(link.tx_data),  64'h23);
    end
    drain(50, c);
    check("bp_cycles", 64'(c), 64'd8);
    step(1'b1, 1'b0, 64'd0);
    check("bp_idle", 64'(link.tx_valid), 64'd0);

    // Back-to-back frames.
    step(1'b1, 1'b1, 64'h1);
    push_frame(64'h1);
    step(1'b1, 1'b1, 64'h2);
    push_frame(64'h2);
    drain(60, c);
    check("b2b_cycles", 64'(c), 64'd20);
    step(1'b1, 1'b0, 64'd0);
    check("b2b_idle", 64'(link.tx_valid), 64'd0);

    // Overflow: one frame parked in the FSM, then 20 strobes with the link stalled.
    step(1'b0, 1'b1, 64'hA0A0_0000_0000_A0A0);
    push_frame(64'hA0A0_0000_0000_A0A0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 64'h1000 + 64'(i));
      if (i < 16) push_frame(64'h1000 + 64'(i));
    end
    step(1'b0, 1'b0, 64'd0);
    check("ovf_full",       64'(fifo_full),     64'd1);
    check("ovf_drop",       64'(drop_count),    64'd4);
    check("ovf_hold_valid", 64'(link.tx_valid), 64'd1);
    check("ovf_hold_data",  64'(link.tx_data),  64'hA5);

    // Full plus pop collision: strobe while the CSUM byte is accepted.
    guard = 0;
    while (exp_q.size() > 161 && guard < 20) begin
      step(1'b1, 1'b0, 64'd0);
      guard++;
    end
    step(1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    step(1'b1, 1'b0, 64'd0);
    check("coll_drop", 64'(drop_count), 64'd5);
    check("coll_full", 64'(fifo_full),  64'd0);
    drain(400, c);
    check("ovf_cycles", 64'(c), 64'd159);
    step(1'b1, 1'b0, 64'd0);
    check("ovf_idle",  64'(link.tx_valid), 64'd0);
    check("ovf_empty", 64'(fifo_empty),    64'd1);

    // Reset while byte 4 of a frame is on the link.
    step(1'b1, 1'b1, 64'h1122334455667788);
    push_frame(64'h1122334455667788);
    guard = 0;
    while (exp_q.size() > 6 && guard < 20) begin
      step(1'b1, 1'b0, 64'd0);
      guard++;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_tx_valid", 64'(link.tx_valid), 64'd0);
    check("mrst_tx_data",  64'(link.tx_data),  64'h00);
    check("mrst_empty",    64'(fifo_empty),    64'd1);
    check("mrst_drop",     64'(drop_count),    64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b1, 64'hFF);
    push_frame(64'hFF);
    drain(50, c);
    check("post_rst_cycles", 64'(c), 64'd11);
    step(1'b1, 1'b0, 64'd0);
    check("post_rst_idle", 64'(link.tx_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
